// File: rtl/gate_sweep_if.sv
// Bundle between the gate-bank sweep checker and its environment: control,
// the a/b stimulus it drives, the seven gate results it samples, and status.
interface gate_sweep_if;
    logic       start;
    logic       a_out;
    logic       b_out;
    logic       and_in;
    logic       or_in;
    logic       nor_in;
    logic       not_in;
    logic       nand_in;
    logic       exor_in;
    logic       exnor_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [6:0] fail_vec;

    // Environment side: requests sweeps and supplies gate-bank results.
    modport master (
        output start, and_in, or_in, nor_in, not_in, nand_in, exor_in, exnor_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_vec
    );

    // Checker side.
    modport slave (
        input  start, and_in, or_in, nor_in, not_in, nand_in, exor_in, exnor_in,
        output a_out, b_out, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Start-triggered stimulus/check stage for a two-input gate bank. Each start
// walks (a,b) through 00,10,01,11 for PASSES sweeps, waits SETTLE_CYCLES after
// driving each vector, compares the seven gate outputs against golden values
// and accumulates a saturating error count and a sticky per-gate fail mask.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic         clk,
    input  logic         rst,
    gate_sweep_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [3:0] SETTLE_LAST = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    // Expected gate-bank outputs, packed {xnor,xor,nand,not,nor,or,and}.
    function automatic logic [6:0] golden(input logic a, input logic b);
        golden = {~(a ^ b), (a ^ b), ~(a & b), ~a, ~(a | b), (a | b), (a & b)};
    endfunction

    state_t      state_r,      state_nxt;
    logic [1:0]  idx_r,        idx_nxt;
    logic [7:0]  pass_cnt_r,   pass_cnt_nxt;
    logic [3:0]  settle_cnt_r, settle_cnt_nxt;
    logic        a_r,          a_nxt;
    logic        b_r,          b_nxt;
    logic [7:0]  err_r,        err_nxt;
    logic [6:0]  fail_r,       fail_nxt;
    logic [6:0]  sampled_s;
    logic [6:0]  mismatch_s;

    assign sampled_s  = {bus.exnor_in, bus.exor_in, bus.nand_in, bus.not_in,
                         bus.nor_in, bus.or_in, bus.and_in};
    // Golden comes from the registered stimulus, so it matches what the bank sees.
    assign mismatch_s = golden(a_r, b_r) ^ sampled_s;

    // State and datapath registers; all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= 2'd0;
            pass_cnt_r   <= 8'd0;
            settle_cnt_r <= 4'd0;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            err_r        <= 8'd0;
            fail_r       <= 7'd0;
        end else begin
            state_r      <= state_nxt;
            idx_r        <= idx_nxt;
            pass_cnt_r   <= pass_cnt_nxt;
            settle_cnt_r <= settle_cnt_nxt;
            a_r          <= a_nxt;
            b_r          <= b_nxt;
            err_r        <= err_nxt;
            fail_r       <= fail_nxt;
        end
    end

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_nxt      = state_r;
        idx_nxt        = idx_r;
        pass_cnt_nxt   = pass_cnt_r;
        settle_cnt_nxt = settle_cnt_r;
        a_nxt          = a_r;
        b_nxt          = b_r;
        err_nxt        = err_r;
        fail_nxt       = fail_r;
        case (state_r)
            IDLE, DONE: begin
                // Start is honoured only here; a/b keep their last values.
                if (bus.start) begin
                    state_nxt    = DRIVE;
                    idx_nxt      = 2'd0;
                    pass_cnt_nxt = 8'd0;
                    err_nxt      = 8'd0;
                    fail_nxt     = 7'd0;
                end else begin
                    state_nxt = state_r;
                end
            end
            DRIVE: begin
                a_nxt          = idx_r[0];
                b_nxt          = idx_r[1];
                settle_cnt_nxt = 4'd0;
                if (HAS_SETTLE) begin
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = CHECK;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt_r + 4'd1;
                end
            end
            CHECK: begin
                fail_nxt = fail_r | mismatch_s;
                if ((|mismatch_s) && (err_r != 8'hFF)) begin
                    err_nxt = err_r + 8'd1;
                end else begin
                    err_nxt = err_r;
                end
                if (idx_r == 2'd3) begin
                    if (pass_cnt_r == PASS_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt      = 2'd0;
                        pass_cnt_nxt = pass_cnt_r + 8'd1;
                        state_nxt    = DRIVE;
                    end
                end else begin
                    idx_nxt   = idx_r + 2'd1;
                    state_nxt = DRIVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = (state_r == DRIVE) || (state_r == SETTLE) || (state_r == CHECK);
    assign bus.done      = (state_r == DONE);
    assign bus.pass      = (state_r == DONE) && (err_r == 8'd0);
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-contained sequential stimulus/check stage for the two-input gate bank (and, or, nor, not, nand, xor, xnor).
- Upstream side: drives the bank's a/b inputs through all four input combinations.
- Downstream side: samples the bank's seven outputs, compares them against golden values, and reports per-gate failures, an error count and pass/done status.
- Replaces free-running toggle stimulus with a start-triggered, repeatable sweep usable on hardware and in simulation.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a/b and sampling outputs; legal 0..15.
- PASSES, 1, number of complete 4-vector sweeps per start; legal 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE or DONE
- a_out  output  1  drives gate-bank input a
- b_out  output  1  drives gate-bank input b
- and_in  input  1  gate-bank and result
- or_in  input  1  gate-bank or result
- nor_in  input  1  gate-bank nor result
- not_in  input  1  gate-bank not result (golden = ~a)
- nand_in  input  1  gate-bank nand result
- exor_in  input  1  gate-bank xor result
- exnor_in  input  1  gate-bank xnor result
- busy  output  1  high from DRIVE through the last CHECK
- done  output  1  level, high while in DONE
- pass  output  1  done && err_count==0
- err_count  output  8  count of failing vectors, saturating at 255
- fail_vec  output  7  sticky per-gate mismatch; bit order {exnor,exor,nand,not,nor,or,and}, and = bit0

Behaviour:
- Reset (async, any state): state=IDLE; vector index idx=0; pass counter=0; settle counter=0; a_out=b_out=0; busy=done=pass=0; err_count=0; fail_vec=0.
- Vector mapping: a_out=idx[0], b_out=idx[1]; idx sequence 0,1,2,3, giving (a,b)=(0,0),(1,0),(0,1),(1,1).
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: start=1 -> DRIVE; clear idx, pass counter, err_count, fail_vec.
  - DRIVE (1 cycle): register a_out/b_out from idx. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
  - SETTLE: remain exactly SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK (1 cycle): compute golden values from the registered a_out/b_out. mismatch[6:0] = golden XOR sampled inputs.
    - fail_vec |= mismatch.
    - If |mismatch, err_count increments by 1 (holds at 255).
    - If idx==3 and pass counter==PASSES-1 -> DONE.
    - Else if idx==3: idx=0, pass counter +1, -> DRIVE.
    - Else: idx +1, -> DRIVE.
  - DONE: done=1; a_out/b_out hold their last values. start=1 -> behaves as start from IDLE (clears status, -> DRIVE).
- Latency: each vector takes SETTLE_CYCLES+2 cycles. done rises exactly PASSES*4*(SETTLE_CYCLES+2) cycles after the cycle in which start is sampled.
- start while busy: ignored, with no effect on the sweep or counters.
- err_count and fail_vec update only in CHECK. They hold their values in DONE until the next start.
- pass is combinational from done and err_count; it is 0 whenever done=0.
- Unknown/X inputs are not qualified; they are compared as sampled.

Test Plan:
- Correct gate bank, SETTLE=2, PASSES=1, start pulse -> (a,b) steps 00,10,01,11 at 4-cycle spacing; done rises 16 cycles after start; pass=1, err_count=0, fail_vec=0.
- and_in stuck at 0 -> only vector 11 fails; err_count=1, fail_vec=7'b0000001, pass=0.
- exor_in inverted, PASSES=2 -> every vector fails; err_count=8, fail_vec=7'b0100000.
- All inputs stuck at 0, PASSES=70, SETTLE=0 -> 280 failing vectors; err_count saturates at 255; done after 560 cycles.
- rst asserted asynchronously during the SETTLE of vector 2 -> outputs clear immediately, state=IDLE. A new start then produces a full clean sweep with err_count=0.
- start pulsed again mid-sweep, then start pulsed in DONE -> mid-sweep pulse has no effect (done timing unchanged). DONE pulse clears err_count/fail_vec and restarts at idx=0 on the next cycle.
